// File: rtl/icap_pkg.sv
// ----------------------------------------------------------------------------
// icap_pkg
// Shared ICAPE2 definitions: configuration command words, configuration
// register addresses and the readback sequencer state type. The multiboot
// reboot sequencer imports the same package.
// ----------------------------------------------------------------------------
package icap_pkg;

  // Command / packet words, logical (unswapped) bit order
  localparam logic [31:0] ICAP_DUMMY       = 32'hFFFF_FFFF;
  localparam logic [31:0] ICAP_SYNC        = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOP         = 32'h2000_0000;
  localparam logic [31:0] ICAP_DESYNC_HDR  = 32'h3000_8001; // Type-1 write CMD, 1 word
  localparam logic [31:0] ICAP_CMD_DESYNC  = 32'h0000_000D;
  localparam logic [31:0] ICAP_CMD_IPROG   = 32'h0000_000F;
  localparam logic [31:0] ICAP_RD_HDR_BASE = 32'h2800_0001; // Type-1 read, 1 word

  // Configuration register addresses
  localparam logic [4:0] REG_STAT    = 5'h07;
  localparam logic [4:0] REG_IDCODE  = 5'h0C;
  localparam logic [4:0] REG_WBSTAR  = 5'h10;
  localparam logic [4:0] REG_BOOTSTS = 5'h16;

  typedef enum logic [2:0] {
    IDLE,
    WR_HDR,
    TO_RD,
    RD_WAIT,
    TO_WR1,
    TO_WR2,
    DESYNC,
    FIN
  } icap_rd_state_t;

  // Type-1 read header: register address sits in bits [17:13]
  function automatic logic [31:0] icap_rd_hdr(input logic [4:0] sel);
    return ICAP_RD_HDR_BASE | {14'd0, sel, 13'd0};
  endfunction

endpackage

// File: rtl/icap_bitswap.sv
// ----------------------------------------------------------------------------
// icap_bitswap
// Per-byte bit reversal between logical word order and the raw ICAPE2
// primitive order. The mapping is its own inverse, so the same block serves
// both the write and the read paths.
// Ports:
//   i_word  in  32  word in either order
//   o_word  out 32  word with the bits of every byte reversed
// ----------------------------------------------------------------------------
module icap_bitswap (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    for (genvar k = 0; k < 8; k++) begin : g_bit
      assign o_word[8*b + k] = i_word[8*b + 7 - k];
    end
  end

endmodule

// File: rtl/icap_status_reader.sv
// ----------------------------------------------------------------------------
// icap_status_reader
// ICAPE2 readback sequencer. On a request it syncs the configuration logic,
// issues a Type-1 read of one configuration register, captures the returned
// word (converted back to logical bit order) and desyncs again.
// Every output is a register loaded from the decode of the current state, so
// the ICAP pins trail the state register by one cycle.
// Ports:
//   clk         in   1   ICAP clock
//   rst_n       in   1   asynchronous active-low reset
//   req         in   1   start pulse, sampled only in IDLE
//   reg_sel     in   5   configuration register address, latched at accept
//   busy        out  1   sequence in progress
//   done        out  1   one-cycle pulse, rdata valid from here on
//   rdata       out  32  last captured word
//   icap_owned  out  1   ICAP mux select for the top level (equals busy)
//   icap_csib   out  1   ICAP chip select, active low
//   icap_rdwrb  out  1   0 = write, 1 = read
//   icap_i      out  32  word to ICAP, logical order
//   icap_o      in   32  word from ICAP, raw primitive order
// ----------------------------------------------------------------------------
module icap_status_reader
  import icap_pkg::*;
#(
  parameter int          READ_LAT   = 4,
  parameter logic [31:0] DUMMY_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] SYNC_WORD  = 32'hAA99_5566
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [4:0]  reg_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        icap_owned,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  if (READ_LAT < 3 || READ_LAT > 15) begin : g_bad_read_lat
    $error("icap_status_reader: READ_LAT must be within 3..15");
  end

  localparam logic [3:0] LAST_RD = 4'(READ_LAT - 1);

  icap_rd_state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [4:0]  r_sel;
  logic        r_busy, r_done, r_csib, r_rdwrb;
  logic [31:0] r_rdata, r_icap_i;

  logic        w_busy, w_done, w_csib, w_rdwrb, w_capture;
  logic [31:0] w_icap_i, w_icap_o_sw;

  icap_bitswap u_rd_swap (
    .i_word (icap_o),
    .o_word (w_icap_o_sw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 4'd1;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_csib      = 1'b1;
    w_rdwrb     = 1'b0;
    w_icap_i    = DUMMY_WORD;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (req) w_state_nxt = WR_HDR;
      end
      WR_HDR: begin
        // slot 0 is the pad word with CSIB still high
        w_csib = (r_cnt == 4'd0);
        case (r_cnt)
          4'd0:    w_icap_i = DUMMY_WORD;
          4'd1:    w_icap_i = SYNC_WORD;
          4'd3:    w_icap_i = icap_rd_hdr(r_sel);
          default: w_icap_i = ICAP_NOP;
        endcase
        if (r_cnt == 4'd5) w_state_nxt = TO_RD;
      end
      TO_RD: begin
        // direction flips only while deselected
        w_rdwrb     = 1'b1;
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        w_csib  = 1'b0;
        w_rdwrb = 1'b1;
        if (r_cnt == LAST_RD) begin
          w_capture   = 1'b1;
          w_state_nxt = TO_WR1;
        end
      end
      TO_WR1: begin
        w_rdwrb     = 1'b1;
        w_state_nxt = TO_WR2;
      end
      TO_WR2: begin
        w_state_nxt = DESYNC;
      end
      DESYNC: begin
        w_csib = 1'b0;
        case (r_cnt)
          4'd0:    w_icap_i = ICAP_DESYNC_HDR;
          4'd1:    w_icap_i = ICAP_CMD_DESYNC;
          default: w_icap_i = ICAP_NOP;
        endcase
        if (r_cnt == 4'd3) w_state_nxt = FIN;
      end
      FIN: begin
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // shared counter restarts at every state entry and idles at zero
    if (w_state_nxt != r_state || r_state == IDLE) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_csib   <= 1'b1;
      r_rdwrb  <= 1'b0;
      r_icap_i <= DUMMY_WORD;
      r_rdata  <= '0;
    end else begin
      if (r_state == IDLE && req) r_sel <= reg_sel;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_csib   <= w_csib;
      r_rdwrb  <= w_rdwrb;
      r_icap_i <= w_icap_i;
      if (w_capture) r_rdata <= w_icap_o_sw;
    end
  end

  assign busy       = r_busy;
  assign icap_owned = r_busy;
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign icap_csib  = r_csib;
  assign icap_rdwrb = r_rdwrb;
  assign icap_i     = r_icap_i;

endmodule

// File: tb/tb_icap_status_reader.sv
// ----------------------------------------------------------------------------
// tb_icap_status_reader
// Directed bench for the ICAP readback sequencer: one instance with the
// default read latency, one with READ_LAT=7. ICAP return data is given as
// hand-swapped raw words; expected words and latencies are hand-computed.
// ----------------------------------------------------------------------------
module tb_icap_status_reader;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, req7 = 1'b0;
  logic [4:0]  reg_sel = '0;
  logic [31:0] icap_o = '0;

  logic        busy, done, owned, csib, rdwrb;
  logic [31:0] rdata, icap_i;
  logic        busy7, done7, owned7, csib7, rdwrb7;
  logic [31:0] rdata7, icap_i7;

  icap_status_reader dut (
    .clk(clk), .rst_n(rst_n), .req(req), .reg_sel(reg_sel),
    .busy(busy), .done(done), .rdata(rdata), .icap_owned(owned),
    .icap_csib(csib), .icap_rdwrb(rdwrb), .icap_i(icap_i), .icap_o(icap_o)
  );

  icap_status_reader #(.READ_LAT(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .req(req7), .reg_sel(reg_sel),
    .busy(busy7), .done(done7), .rdata(rdata7), .icap_owned(owned7),
    .icap_csib(csib7), .icap_rdwrb(rdwrb7), .icap_i(icap_i7), .icap_o(icap_o)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  // ---- protocol monitor, sampled on the falling edge ----
  logic [31:0] wq[$], wq7[$];
  int tog_err = 0, own_err = 0, done_cnt = 0;
  logic p_busy = 0, p_csib = 1, p_rdwrb = 0;
  logic p_busy7 = 0, p_csib7 = 1, p_rdwrb7 = 0;

  always @(negedge clk) begin
    if (busy && !p_busy) wq.delete();
    if (!csib && !rdwrb) wq.push_back(icap_i);
    if (!csib && !p_csib && rdwrb !== p_rdwrb) tog_err++;
    if (busy !== owned) own_err++;
    if (done) done_cnt++;
    p_busy = busy; p_csib = csib; p_rdwrb = rdwrb;

    if (busy7 && !p_busy7) wq7.delete();
    if (!csib7 && !rdwrb7) wq7.push_back(icap_i7);
    if (!csib7 && !p_csib7 && rdwrb7 !== p_rdwrb7) tog_err++;
    if (busy7 !== owned7) own_err++;
    p_busy7 = busy7; p_csib7 = csib7; p_rdwrb7 = rdwrb7;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, optionally pulse req at accept+3 and at the FIN
  // sample edge fin_k; returns done latency in edges and busy cycle count.
  task automatic run(input bit use7, input logic [4:0] sel, input logic [31:0] raw,
                     input bit inject, input int fin_k, output int lat, output int bcnt);
    icap_o  = raw;
    reg_sel = sel;
    if (use7) req7 = 1'b1; else req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; req7 = 1'b0;
    reg_sel = ~sel;  // must have no effect after accept
    lat = -1; bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (inject && (k == 3 || k == fin_k)) req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      if (use7 ? busy7 : busy) bcnt++;
      if (use7 ? done7 : done) begin lat = k; break; end
    end
  endtask

  task automatic chk_words(input string tag, input logic [31:0] hdr);
    logic [31:0] exp_w [9];
    exp_w = '{32'hAA995566, 32'h20000000, hdr, 32'h20000000, 32'h20000000,
              32'h30008001, 32'h0000000D, 32'h20000000, 32'h20000000};
    chk({tag, "_nwords"}, 32'(wq.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_w%0d", tag, i), (i < wq.size()) ? wq[i] : 32'hxxxxxxxx, exp_w[i]);
  endtask

  int lat, bc, d0;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_owned", {31'd0, owned}, 32'd0);
    chk("rst_csib",  {31'd0, csib},  32'd1);
    chk("rst_rdwrb", {31'd0, rdwrb}, 32'd0);
    chk("rst_rdata", rdata,          32'd0);
    chk("rst_icapi", icap_i,         32'hFFFFFFFF);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- BOOTSTS read: raw 0x00000080 is the swap of 0x00000001 ----
    run(0, 5'h16, 32'h00000080, 0, 0, lat, bc);
    chk("boot_lat",   32'(lat), 32'd18);
    chk("boot_busy",  32'(bc),  32'd17);
    chk("boot_rdata", rdata,    32'h00000001);
    chk_words("boot", 32'h2802C001);
    @(posedge clk); #1;
    chk("boot_done_pulse", {31'd0, done}, 32'd0);

    // ---- WBSTAR read with READ_LAT=7: raw 0x00800000 ----
    run(1, 5'h10, 32'h00800000, 0, 0, lat, bc);
    chk("wb7_lat",    32'(lat), 32'd21);
    chk("wb7_busy",   32'(bc),  32'd20);
    chk("wb7_rdata",  rdata7,   32'h00010000);
    chk("wb7_nwords", 32'(wq7.size()), 32'd9);
    chk("wb7_hdr",    (wq7.size() > 2) ? wq7[2] : 32'hxxxxxxxx, 32'h28020001);

    // ---- ignored requests at accept+3 and during FIN ----
    d0 = done_cnt;
    run(0, 5'h10, 32'h00800000, 1, 18, lat, bc);
    chk("ign_lat",   32'(lat), 32'd18);
    chk("ign_rdata", rdata,    32'h00010000);
    chk_words("ign", 32'h28020001);
    icap_o = 32'hDEADBEEF;
    repeat (25) @(posedge clk);
    #1;
    chk("ign_ndone", 32'(done_cnt - d0), 32'd1);
    chk("ign_idle",  {31'd0, busy},      32'd0);
    chk("ign_hold",  rdata,              32'h00010000);

    // ---- back-to-back IDCODE then STAT ----
    run(0, 5'h0C, 32'hC0460BC9, 0, 0, lat, bc);
    chk("id_lat",   32'(lat), 32'd18);
    chk("id_rdata", rdata,    32'h0362D093);
    chk_words("id", 32'h28018001);
    run(0, 5'h07, 32'h02089E3F, 0, 0, lat, bc);
    chk("stat_lat",   32'(lat), 32'd18);
    chk("stat_rdata", rdata,    32'h401079FC);
    chk_words("stat", 32'h2800E001);

    // ---- asynchronous reset in the middle of RD_WAIT ----
    icap_o  = 32'h00000080;
    reg_sel = 5'h16;
    req     = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_csib_low", {31'd0, csib},  32'd0);
    chk("mid_rd_dir",   {31'd0, rdwrb}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_csib",  {31'd0, csib},  32'd1);
    chk("arst_busy",  {31'd0, busy},  32'd0);
    chk("arst_owned", {31'd0, owned}, 32'd0);
    chk("arst_rdata", rdata,          32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 5'h0C, 32'hC0460BC9, 0, 0, lat, bc);
    chk("rec_lat",   32'(lat), 32'd18);
    chk("rec_rdata", rdata,    32'h0362D093);
    chk_words("rec", 32'h28018001);

    // ---- protocol summary ----
    chk("proto_rdwrb_toggle", 32'(tog_err), 32'd0);
    chk("owned_eq_busy",      32'(own_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
